// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths and defaults for sync_fifo.
// Provides ptr_w(), which gives the pointer width $clog2(DEPTH)+1, and the
// default N and DEPTH. Optional feature macro used elsewhere: SYNC_FIFO_COUNT_EN.
package sync_fifo_pkg;
    localparam int N_DEF     = 8;
    localparam int DEPTH_DEF = 8;
    // The extra MSB tells full apart from empty when the low bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake bundle between a producer/consumer and sync_fifo.
// Signals: wr_en, wr_data[N], rd_en (from master); rd_data[N], full, empty,
// overflow, underflow, and count[$clog2(DEPTH)+1] when SYNC_FIFO_COUNT_EN is
// defined (from slave).
// modport master: the producer/consumer side. modport slave: the FIFO side.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic         wr_en;
    logic [N-1:0] wr_data;
    logic         rd_en;
    logic [N-1:0] rd_data;
    logic         full;
    logic         empty;
    logic         overflow;
    logic         underflow;
`ifdef SYNC_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count;
    modport master (output wr_en, wr_data, rd_en,
                    input  rd_data, full, empty, overflow, underflow, count);
    modport slave  (input  wr_en, wr_data, rd_en,
                    output rd_data, full, empty, overflow, underflow, count);
`else
    modport master (output wr_en, wr_data, rd_en,
                    input  rd_data, full, empty, overflow, underflow);
    modport slave  (input  wr_en, wr_data, rd_en,
                    output rd_data, full, empty, overflow, underflow);
`endif
endinterface

// File: rtl/sync_fifo_ptr.sv
// fifo_ptr: wrap-around pointer counter for sync_fifo.
// Ports: clk, rst (async, active-low), inc (advance by one), ptr[W] (current value).
// The pointer wraps naturally modulo 2**W.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parameterised synchronous FIFO with full/empty flags and error pulses.
// Ports: clk, rst (async, active-low), bus (sync_fifo_if.slave): wr_en/wr_data
// in, rd_en in, rd_data out (registered), full, empty, overflow, underflow
// (one-cycle pulses), count (only when SYNC_FIFO_COUNT_EN is defined).
// DEPTH must be a power of two, and at least 2.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] wp, rp;
    logic [N-1:0]  mem [DEPTH];
    logic          wr_ok, rd_ok;

    assign bus.empty = wp == rp;
    assign bus.full  = (wp[PW-1] != rp[PW-1]) && (wp[AW-1:0] == rp[AW-1:0]);
    // When full, a write is refused even if a read is accepted on the same edge.
    // When empty, a read is refused even if a write is accepted on the same edge.
    assign wr_ok = bus.wr_en && !bus.full;
    assign rd_ok = bus.rd_en && !bus.empty;

    fifo_ptr #(.W(PW)) u_wp (.clk(clk), .rst(rst), .inc(wr_ok), .ptr(wp));
    fifo_ptr #(.W(PW)) u_rp (.clk(clk), .rst(rst), .inc(rd_ok), .ptr(rp));

    always_ff @(posedge clk)
        if (wr_ok)
            mem[wp[AW-1:0]] <= bus.wr_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.rd_data   <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (rd_ok)
                bus.rd_data <= mem[rp[AW-1:0]];
            bus.overflow  <= bus.wr_en && bus.full;
            bus.underflow <= bus.rd_en && bus.empty;
        end

`ifdef SYNC_FIFO_COUNT_EN
    assign bus.count = wp - rp;
`endif
endmodule
